// File: rtl/riscv_mem_pkg.sv
//==============================================================================
// Module  : riscv_mem_pkg
// Brief   : Shared widths and FSM state encoding for the data-memory responder.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package riscv_mem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
//==============================================================================
// Module  : dmem_array
// Brief   : DEPTH x 32 synchronous RAM, per-byte write enable, registered read.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_array
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // One byte-wide memory per lane keeps the byte enables a plain write gate.
    for (genvar i = 0; i < BE_W; i++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (we && be[i]) begin
                r_mem[addr] <= wdata[8*i +: 8];
            end
            if (re) begin
                r_q <= r_mem[addr];
            end
        end

        assign rdata[8*i +: 8] = r_q;
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
//==============================================================================
// Module  : dmem_responder
// Brief   : Single-outstanding valid/ready data-memory responder with latency.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;

    logic                w_accept;
    logic                w_access;
    logic                w_err;
    logic                w_ram_we;
    logic                w_ram_re;
    logic [DATA_W-1:0]   w_ram_rdata;

    // Captured address is stable through WAIT and RESP, so the error is derived from it.
    assign w_err = (r_addr[1:0] != 2'b00) || (r_addr[31:AW+2] != '0);

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_cnt   <= C_CNT_LOAD;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign w_ram_we = w_access &&  r_we && !w_err;
    assign w_ram_re = w_access && !r_we && !w_err;

    // The RAM output register only loads on a read access, so it holds through RESP.
    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (w_ram_we),
        .re    (w_ram_re),
        .be    (r_be),
        .addr  (r_addr[AW+1:2]),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    assign rsp_valid = (r_state == RESP);
    assign rsp_err   = rsp_valid && w_err;
    assign rsp_rdata = (rsp_valid && !w_err && !r_we) ? w_ram_rdata : '0;

endmodule

`default_nettype wire
